// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared sizes, state encoding and word types for the mvm engine
package mvm_pkg;

    localparam int N    = 4;
    localparam int DW   = 4;
    localparam int ACCW = 10;
    localparam int CNTW = $clog2(N * N);
    localparam int IDXW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mvm_state_t;

    typedef logic [DW-1:0]   data_t;
    typedef logic [ACCW-1:0] acc_t;
    typedef logic [CNTW-1:0] cnt_t;
    typedef logic [IDXW-1:0] idx_t;

endpackage

// File: rtl/mvm_mac.sv
// rtl/mvm_mac.sv - one row multiply-accumulate with clear, enable and saturated look-ahead
module mvm_mac
    import mvm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  en,
    input  data_t w,
    input  data_t x,
    output data_t sat_next
);

    logic [2*DW-1:0] prod;
    acc_t            acc;
    acc_t            acc_sum;
    acc_t            acc_view;

    assign prod    = {{DW{1'b0}}, w} * {{DW{1'b0}}, x};
    assign acc_sum = acc + {{(ACCW-2*DW){1'b0}}, prod};

    // Saturate the value the row holds once this edge's product is included,
    // so the top can capture the final sum on the same edge that adds it.
    always_comb begin
        acc_view = en ? acc_sum : acc;
        sat_next = (|acc_view[ACCW-1:DW]) ? '1 : acc_view[DW-1:0];
    end

    // Accumulator: clear wins over accumulate so a restart never mixes runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/mvm.sv
// rtl/mvm.sv - 4x4 matrix-vector multiply with serial weights and saturated row outputs
module mvm
    import mvm_pkg::*;
(
    input  logic  i_clk_mvm,
    input  logic  i_rst_mvm,
    input  logic  i_start_mvm,
    input  data_t i_x_bn [N-1:0],
    input  data_t i_w_mvm,
    output logic  o_ismvm,
    output data_t o_wx_result [N-1:0]
);

    mvm_state_t state;
    mvm_state_t state_next;
    cnt_t       k;
    data_t      x_reg [N-1:0];
    data_t      sat_row [N-1:0];
    logic [N-1:0] row_en;
    logic       busy;
    logic       last;
    logic       clr;
    idx_t       row;
    idx_t       col;

    assign row = k[CNTW-1:IDXW];
    assign col = k[IDXW-1:0];

    // State register.
    always_ff @(posedge i_clk_mvm) begin
        if (i_rst_mvm) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a start on the final busy edge chains straight into a new run.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start_mvm) state_next = BUSY;
            BUSY:    if (last && !i_start_mvm) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control decode: busy flag, final-weight edge and run (re)start.
    always_comb begin
        busy    = (state == BUSY);
        last    = busy && (k == cnt_t'(N*N-1));
        clr     = i_start_mvm && (!busy || last);
        o_ismvm = busy;
    end

    // Weight index; wraps to zero after the last weight of a run.
    always_ff @(posedge i_clk_mvm) begin
        if (i_rst_mvm) begin
            k <= '0;
        end else if (clr) begin
            k <= '0;
        end else if (busy) begin
            k <= k + cnt_t'(1);
        end
    end

    // Input vector is captured once per run so later changes cannot leak in.
    always_ff @(posedge i_clk_mvm) begin
        for (int i = 0; i < N; i++) begin
            if (i_rst_mvm) begin
                x_reg[i] <= '0;
            end else if (clr) begin
                x_reg[i] <= i_x_bn[i];
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        assign row_en[r] = busy && (row == idx_t'(r));

        mvm_mac u_mac (
            .clk      (i_clk_mvm),
            .rst      (i_rst_mvm),
            .clr      (clr),
            .en       (row_en[r]),
            .w        (i_w_mvm),
            .x        (x_reg[col]),
            .sat_next (sat_row[r])
        );
    end

    // Results hold during a run and update only on its final edge.
    always_ff @(posedge i_clk_mvm) begin
        for (int i = 0; i < N; i++) begin
            if (i_rst_mvm) begin
                o_wx_result[i] <= '0;
            end else if (last) begin
                o_wx_result[i] <= sat_row[i];
            end
        end
    end

endmodule

// File: tb/tb_mvm.sv
// tb/tb_mvm.sv - self-checking bench for mvm against a plain arithmetic row-sum model
module tb_mvm;
    import mvm_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  start;
    data_t x_bn [N-1:0];
    data_t w;
    logic  ismvm;
    data_t res [N-1:0];

    int    total = 0;
    int    bad = 0;
    data_t xv [N];
    data_t wv [N*N];
    data_t xn [N];
    data_t prev_exp [N];
    int    busy_len;
    int    exp_len;

    always #5 clk = ~clk;

    mvm dut (
        .i_clk_mvm   (clk),
        .i_rst_mvm   (rst),
        .i_start_mvm (start),
        .i_x_bn      (x_bn),
        .i_w_mvm     (w),
        .o_ismvm     (ismvm),
        .o_wx_result (res)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag);
        for (int r = 0; r < N; r++) begin
            chk($sformatf("%s[%0d]", tag, r), 32'(res[r]), 32'(prev_exp[r]));
        end
    endtask

    task automatic model();
        for (int r = 0; r < N; r++) begin
            int s;
            s = 0;
            for (int c = 0; c < N; c++) begin
                s += int'(wv[r*N+c]) * int'(xv[c]);
            end
            prev_exp[r] = (s > 15) ? data_t'(15) : data_t'(s);
        end
    endtask

    task automatic rand_vecs(input int xmax, input int wmax);
        for (int c = 0; c < N; c++) xv[c] = data_t'($urandom_range(0, xmax));
        for (int i = 0; i < N*N; i++) wv[i] = data_t'($urandom_range(0, wmax));
    endtask

    task automatic run(input bit chain_in, input bit chain_out, input int mid_at, input int abort_at);
        if (!chain_in) begin
            @(negedge clk);
            start = 1'b1;
            for (int c = 0; c < N; c++) x_bn[c] = xv[c];
            busy_len = 0;
            exp_len  = 0;
        end
        exp_len += N*N;
        for (int k = 0; k < N*N; k++) begin
            @(negedge clk);
            chk($sformatf("busy_k%0d", k), 32'(ismvm), 32'd1);
            busy_len += ismvm ? 1 : 0;
            chk_res("hold");
            if (k == abort_at) begin
                rst   = 1'b1;
                start = 1'b0;
                @(negedge clk);
                chk("abort_busy", 32'(ismvm), 32'd0);
                for (int r = 0; r < N; r++) prev_exp[r] = '0;
                chk_res("abort_res");
                rst = 1'b0;
                return;
            end
            w     = wv[k];
            start = 1'b0;
            if (k == mid_at) begin
                start = 1'b1;
                for (int c = 0; c < N; c++) x_bn[c] = data_t'($urandom);
            end
            if (k == N*N-1 && chain_out) begin
                start = 1'b1;
                for (int c = 0; c < N; c++) x_bn[c] = xn[c];
            end
        end
        model();
        if (!chain_out) begin
            @(negedge clk);
            chk("idle_after", 32'(ismvm), 32'd0);
            chk("busy_len", 32'(busy_len), 32'(exp_len));
            chk_res("result");
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        w     = '0;
        for (int c = 0; c < N; c++) x_bn[c] = '0;
        for (int r = 0; r < N; r++) prev_exp[r] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state and idle with toggling weights
        chk("rst_busy", 32'(ismvm), 32'd0);
        chk_res("rst_res");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            w = data_t'($urandom);
            chk("idle_busy", 32'(ismvm), 32'd0);
            chk_res("idle_res");
        end

        // saturation run: every row sums to 256
        for (int c = 0; c < N; c++) xv[c] = data_t'(8);
        for (int i = 0; i < N*N; i++) wv[i] = data_t'(8);
        run(1'b0, 1'b0, -1, -1);
        chk("sat_row0", 32'(res[0]), 32'hF);

        // row-distinct run: weights equal the row index
        for (int c = 0; c < N; c++) xv[c] = data_t'(1);
        for (int i = 0; i < N*N; i++) wv[i] = data_t'(i / N);
        run(1'b0, 1'b0, -1, -1);
        chk("rowd_row3", 32'(res[3]), 32'd12);
        chk("rowd_row1", 32'(res[1]), 32'd4);

        // start and x change mid-run are ignored
        rand_vecs(3, 3);
        run(1'b0, 1'b0, 5, -1);

        // reset aborts a run; a full run afterwards is clean
        rand_vecs(15, 15);
        run(1'b0, 1'b0, -1, 8);
        rand_vecs(3, 2);
        run(1'b0, 1'b0, -1, -1);

        // back-to-back runs with no gap cycle
        rand_vecs(3, 3);
        for (int c = 0; c < N; c++) xn[c] = data_t'($urandom_range(0, 3));
        run(1'b0, 1'b1, -1, -1);
        for (int c = 0; c < N; c++) xv[c] = xn[c];
        for (int i = 0; i < N*N; i++) wv[i] = data_t'($urandom_range(0, 2));
        run(1'b1, 1'b0, -1, -1);

        // assorted random runs
        for (int t = 0; t < 4; t++) begin
            rand_vecs((t % 2 == 0) ? 2 : 15, (t % 2 == 0) ? 2 : 15);
            run(1'b0, 1'b0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
